// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch FSM state, NOP encoding and default reset PC
package instr_fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} fetch_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding 32-bit instruction fetch over a 64-bit read bus with pc redirect buffering
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  output logic        ifu_finish,
  output logic [31:0] instr,
  output logic [63:0] pc,
  input  logic        pc_update,
  input  logic [63:0] next_pc,
  output logic        ibus_req,
  output logic [63:0] ibus_addr,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [63:0] ibus_rdata,
  input  logic        ibus_err,
  output logic        fetch_fault
);
  fetch_state_e r_state;
  logic [63:0] r_pc, r_pend;
  logic [31:0] r_instr;
  logic r_pend_v, r_fin, r_req, r_fault;
  logic [63:0] w_fpc;
  assign w_fpc = pc_update ? next_pc : r_pc;
  assign ifu_finish = r_fin;
  assign instr = r_instr;
  assign pc = r_pc;
  assign ibus_req = r_req;
  assign ibus_addr = {r_pc[63:3], 3'b000};
  assign fetch_fault = r_fault;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc <= RESET_PC;
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_instr <= NOP;
      r_fin <= 1'b0;
      r_req <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pc <= w_fpc;
          if (ifu_valid && w_fpc[1:0] == 2'b00) begin
            r_state <= S_REQ;
            r_req <= 1'b1;
            r_fault <= 1'b0;
          end else if (ifu_valid) begin
            r_state <= S_DONE;
            r_fin <= 1'b1;
            r_instr <= NOP;
            r_fault <= 1'b1;
          end
        end
        S_REQ: begin
          if (pc_update) begin
            r_pend <= next_pc;
            r_pend_v <= 1'b1;
          end
          if (ibus_ready) begin
            r_state <= S_WAIT;
            r_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pc_update) begin
            r_pend <= next_pc;
            r_pend_v <= 1'b1;
          end
          if (ibus_rvalid) begin
            r_state <= S_DONE;
            r_fin <= 1'b1;
            r_instr <= ibus_err ? NOP : (r_pc[2] ? ibus_rdata[63:32] : ibus_rdata[31:0]);
            r_fault <= ibus_err;
          end
        end
        S_DONE: begin
          // a redirect arriving in DONE is newer than anything buffered during the fetch
          r_pc <= pc_update ? next_pc : (r_pend_v ? r_pend : r_pc);
          r_pend_v <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ifu_valid  input  1  fetch request level from control FSM.
REQ-005 SHALL have port ifu_finish  output  1  one-cycle pulse, instr valid.
REQ-006 SHALL have port instr  output  32  fetched instruction, held until next fetch completes.
REQ-007 SHALL have port pc  output  64  address of the instruction in instr / being fetched.
REQ-008 SHALL have port pc_update  input  1  one-cycle pulse, load next_pc.
REQ-009 SHALL have port next_pc  input  64  redirect/sequential target computed downstream.
REQ-010 SHALL have port ibus_req  output  1  bus read request.
REQ-011 SHALL have port ibus_addr  output  64  8-byte-aligned read address.
REQ-012 SHALL have port ibus_ready  input  1  bus accepted request this cycle.
REQ-013 SHALL have port ibus_rvalid  input  1  read data valid.
REQ-014 SHALL have port ibus_rdata  input  64  read data doubleword.
REQ-015 SHALL have port ibus_err  input  1  bus error, qualified by ibus_rvalid.
REQ-016 SHALL have port fetch_fault  output  1  misaligned or bus-error fetch, valid with ifu_finish.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: ifu_valid=1 and pc[1:0]==0 -> REQ; ifu_valid=1 and pc[1:0]!=0 -> DONE with fault; else stay.
REQ-019 REQ: ibus_req=1, ibus_addr={pc[63:3],3'b000}; ibus_ready=1 -> WAIT, else stay with address stable.
REQ-020 WAIT: ibus_req=0; ibus_rvalid=1 -> latch instr, -> DONE; ibus_rvalid in REQ cycle SHALL be ignored.
REQ-021 Latch: instr = pc[2] ? ibus_rdata[63:32] : ibus_rdata[31:0]; ibus_err=1 -> instr=32'h0000_0013 (NOP), fetch_fault=1.
REQ-022 Misaligned path: no bus request, instr=32'h0000_0013, fetch_fault=1.
REQ-023 DONE: ifu_finish=1 for exactly one cycle, -> IDLE unconditionally; minimum latency ifu_valid rise to ifu_finish = 3 cycles (ready and rvalid each 1 cycle).
REQ-024 fetch_fault SHALL be registered with instr and cleared when next fetch leaves IDLE.
REQ-025 ifu_valid SHALL be sampled only in IDLE; deassertion during REQ/WAIT SHALL not abort the fetch.
REQ-026 pc_update in IDLE or DONE: pc<=next_pc next cycle.
REQ-027 pc_update in REQ or WAIT: next_pc SHALL be stored in a pending register; pc<=pending on entry to IDLE; in-flight fetch SHALL use old pc.
REQ-028 Second pc_update while pending: later value SHALL overwrite.
REQ-029 pc_update and ifu_valid same cycle in IDLE: pc update first; fetch SHALL start next cycle from new pc.

Reset
REQ-030 rst SHALL force state=IDLE, pc=RESET_PC, instr=32'h0000_0013, ifu_finish=0, ibus_req=0, fetch_fault=0, pending cleared.
REQ-031 rst mid-fetch SHALL abandon the transaction; a late ibus_rvalid after reset SHALL be ignored in IDLE.

Structure
REQ-032 Shared package SHALL hold fetch state enum, NOP constant 32'h0000_0013, default RESET_PC.
REQ-033 No sub-module; single module with one FSM, PC register, pending-PC register, instruction register.

Verification
REQ-034 Reset, ifu_valid=1, ready next cycle, rvalid next, rdata=64'hAAAA_BBBB_0010_0093 -> ibus_addr=0x80000000, instr=0x00100093, ifu_finish pulse 1 cycle, fetch_fault=0.
REQ-035 pc_update next_pc=0x80000004, fetch, same rdata -> ibus_addr=0x80000000, instr=0xAAAABBBB.
REQ-036 ibus_ready held low 5 cycles -> ibus_req and ibus_addr stable 6 cycles, ifu_finish only after rvalid.
REQ-037 pc_update next_pc=0x80000102 then ifu_valid -> no ibus_req, instr=0x00000013, fetch_fault=1.
REQ-038 pc_update next_pc=0x80000040 during WAIT -> instr from old pc, pc=0x80000040 in IDLE after ifu_finish.
REQ-039 rvalid with ibus_err=1 -> instr=0x00000013, fetch_fault=1; rst during WAIT -> pc=0x80000000, no ifu_finish.
